mem_loader: RTL

Upstream write-port driver for the 8-bit data memory. It accepts a framed byte stream over a valid/ready handshake and writes the payload into consecutive memory locations through the memory's `memwrite`/`address`/`writedata` port. It holds the CPU core stalled via `cpu_hold` until the first frame with a correct checksum has been written. It owns the memory write port only while `busy` is high; the memory read port is never used.

---
 rtl/mem_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Purpose  : Receives a framed byte stream over a valid/ready handshake and
//            writes the payload into consecutive locations of the 8-bit data
//            memory. Holds the CPU stalled until the first frame whose
//            checksum matches has been written.
//
//            Frame: 0xA5, start address, length (0 = 256), payload, XOR sum.
//
// Ports    : clk        in   system clock, rising edge
//            rst        in   asynchronous reset, active low
//            in_valid   in   in_data is valid
//            in_data    in   [7:0] stream byte
//            pause      in   back-pressure, forces in_ready low
//            in_ready   out  byte accepted when in_valid & in_ready
//            memwrite   out  registered memory write strobe
//            memread    out  tied low, the read port is never used
//            address    out  [7:0] registered memory address
//            writedata  out  [7:0] registered memory write data
//            busy       out  a frame is in progress
//            done       out  one-cycle pulse on a good frame
//            err        out  sticky bad-checksum flag, cleared by next sync
//            cpu_hold   out  CPU stall, released by the first good frame
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       pause,
  output logic       in_ready,
  output logic       memwrite,
  output logic       memread,
  output logic [7:0] address,
  output logic [7:0] writedata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cpu_hold
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] xor_q, xor_d;
  logic       memwrite_q, memwrite_d;
  logic [7:0] address_q, address_d;
  logic [7:0] writedata_q, writedata_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       hold_q, hold_d;
  logic       accept;

  // Gating with rst keeps in_ready low for the whole time reset is asserted
  // and lets it rise as soon as reset is released.
  assign in_ready = rst & ~pause & (state_q != S_DONE);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 8'h00;
      cnt_q       <= 9'd0;
      xor_q       <= 8'h00;
      memwrite_q  <= 1'b0;
      address_q   <= 8'h00;
      writedata_q <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hold_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      xor_q       <= xor_d;
      memwrite_q  <= memwrite_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    xor_d       = xor_q;
    memwrite_d  = 1'b0;   // strobe only in the cycle after a payload byte
    address_d   = address_q;
    writedata_d = writedata_q;
    done_d      = 1'b0;   // pulse
    err_d       = err_q;
    hold_d      = hold_q;

    case (state_q)
      S_IDLE: begin
        // Non-sync bytes are consumed and dropped so the stream can resync.
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d = S_ADDR;
          err_d   = 1'b0;
        end
      end
      S_ADDR: begin
        if (accept) begin
          ptr_d   = in_data;
          xor_d   = 8'h00;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          memwrite_d  = 1'b1;
          address_d   = ptr_q;
          writedata_d = in_data;
          ptr_d       = ptr_q + 8'd1;   // natural 8-bit wrap
          xor_d       = xor_q ^ in_data;
          cnt_d       = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_data == xor_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign memwrite  = memwrite_q;
  assign memread   = 1'b0;
  assign address   = address_q;
  assign writedata = writedata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_hold  = hold_q;

endmodule
`default_nettype wire
